// File: rtl/voter_session_if.sv
// Bundles the voter-facing inputs and the voting-core-facing outputs of voter_session_ctrl.
interface voter_session_if #(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned VCNT_W   = 8
);
  logic                mode;
  logic                fingerprint_valid;
  logic [NUM_CAND-1:0] button_in;
  logic                fingerprint_ok;
  logic [NUM_CAND-1:0] vote_btn;
  logic                session_active;
  logic                multi_press_err;
  logic                session_timeout;
  logic [VCNT_W-1:0]   voter_count;

  modport master (
    output mode, fingerprint_valid, button_in,
    input  fingerprint_ok, vote_btn, session_active, multi_press_err, session_timeout, voter_count
  );

  modport slave (
    input  mode, fingerprint_valid, button_in,
    output fingerprint_ok, vote_btn, session_active, multi_press_err, session_timeout, voter_count
  );
endinterface

// File: rtl/voter_session_ctrl.sv
// Ballot-session gate: one verified fingerprint opens one session that grants at most one vote pulse.
// Optional ARMED-state abort timer is built when SESSION_TIMEOUT_EN is defined.
module voter_session_ctrl #(
  parameter int unsigned NUM_CAND       = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned VCNT_W         = 8
) (
  input logic             clock,
  input logic             reset,
  voter_session_if.slave  bus
);
  // state        | meaning
  // IDLE         | waiting for a fingerprint rising edge in voting mode
  // ARMED        | voter verified, waiting for one clean single-candidate press
  // CAST         | replaying the granted press downstream for PULSE_CYCLES cycles
  // WAIT_RELEASE | session over, waiting for finger lift and all buttons released
  typedef enum logic [1:0] {IDLE, ARMED, CAST, WAIT_RELEASE} state_e;

  localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                fp_dly_q;
  logic [NUM_CAND-1:0] btn_prev_q;
  logic [NUM_CAND-1:0] vote_lat_q, vote_lat_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [VCNT_W-1:0]   cnt_q, cnt_d;
  logic                ok_q, ok_d, act_q, act_d, err_q, err_d;
  logic [NUM_CAND-1:0] vote_q, vote_d;
  logic                reject;

  logic fp_s, fp_rise, new_press, multi;
  assign fp_s      = sync_q[SYNC_STAGES-1];
  assign fp_rise   = fp_s & ~fp_dly_q;
  assign new_press = (bus.button_in != '0) & (btn_prev_q == '0);
  assign multi     = |(bus.button_in & (bus.button_in - NUM_CAND'(1)));

`ifdef SESSION_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          to_q, to_d;
  logic          tmo;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      fp_dly_q   <= 1'b0;
      btn_prev_q <= '1;
      vote_lat_q <= '0;
      pcnt_q     <= '0;
      cnt_q      <= '0;
      ok_q       <= 1'b0;
      act_q      <= 1'b0;
      err_q      <= 1'b0;
      vote_q     <= '0;
`ifdef SESSION_TIMEOUT_EN
      tmr_q      <= TW'(TIMEOUT_CYCLES - 1);
      to_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.fingerprint_valid};
      fp_dly_q   <= fp_s;
      btn_prev_q <= bus.button_in;
      vote_lat_q <= vote_lat_d;
      pcnt_q     <= pcnt_d;
      cnt_q      <= cnt_d;
      ok_q       <= ok_d;
      act_q      <= act_d;
      err_q      <= err_d;
      vote_q     <= vote_d;
`ifdef SESSION_TIMEOUT_EN
      tmr_q      <= tmr_d;
      to_q       <= to_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    vote_lat_d = vote_lat_q;
    pcnt_d     = pcnt_q;
    cnt_d      = cnt_q;
    reject     = 1'b0;
`ifdef SESSION_TIMEOUT_EN
    tmo        = 1'b0;
    // Reloaded outside ARMED so every session starts with the full budget.
    tmr_d      = (state_q != ARMED) ? TW'(TIMEOUT_CYCLES - 1)
               : (tmr_q != '0) ? tmr_q - TW'(1) : tmr_q;
`endif
    case (state_q)
      IDLE: if (fp_rise && !bus.mode) state_d = ARMED;
      ARMED: begin
        if (!fp_s || bus.mode) begin
          state_d = IDLE;
        end else if (new_press && !multi) begin
          state_d    = CAST;
          vote_lat_d = bus.button_in;
          pcnt_d     = PW'(PULSE_CYCLES - 1);
          if (cnt_q != '1) cnt_d = cnt_q + VCNT_W'(1);
        end else begin
          reject = new_press;
`ifdef SESSION_TIMEOUT_EN
          if (tmr_q == '0) begin
            tmo     = 1'b1;
            state_d = WAIT_RELEASE;
          end
`endif
        end
      end
      CAST: begin
        if (pcnt_q == '0) state_d = WAIT_RELEASE;
        else              pcnt_d  = pcnt_q - PW'(1);
      end
      WAIT_RELEASE: if (!fp_s && (bus.button_in == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    ok_d   = (state_d == ARMED) || (state_d == CAST);
    act_d  = (state_d == ARMED);
    vote_d = (state_d == CAST) ? vote_lat_d : '0;
    err_d  = reject;
`ifdef SESSION_TIMEOUT_EN
    to_d   = tmo;
`endif
  end

  assign bus.fingerprint_ok  = ok_q;
  assign bus.vote_btn        = vote_q;
  assign bus.session_active  = act_q;
  assign bus.multi_press_err = err_q;
  assign bus.voter_count     = cnt_q;
`ifdef SESSION_TIMEOUT_EN
  assign bus.session_timeout = to_q;
`else
  assign bus.session_timeout = 1'b0;
`endif
endmodule
